// File: rtl/rr_mux_sel_stage.sv
// Four-channel round-robin arbiter. It drives the select of an external 4:1 mux
// and holds the returned word in a single-entry valid/ready output register.
module rr_mux_sel_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    output logic [1:0]   sel,
    input  logic [W-1:0] mux_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   last_q, last_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;

    logic [1:0] winner;
    logic       any_req;
    logic       can_load;
    logic       grant;

    // Walk the channels from farthest to nearest so that the nearest requester
    // after last_q writes winner last. With no requester, winner stays at last_q.
    always_comb begin
        winner = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (in_valid[last_q + 2'(k)]) begin
                winner = last_q + 2'(k);
            end
        end
    end

    always_comb begin
        any_req  = |in_valid;
        can_load = !out_valid_q || out_ready;
        grant    = can_load && any_req && !rst;
        sel      = winner;
        in_ready = grant ? (4'b0001 << winner) : 4'b0000;
    end

    always_comb begin
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (grant) begin
            last_d      = winner;
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 2'd3;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rr_mux_sel_stage.sv
// Bench for rr_mux_sel_stage. It models the external 4:1 mux and keeps a queue of
// the words expected on out_data after each handshake.
module tb_rr_mux_sel_stage;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic [W-1:0] mux_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    logic [W-1:0] d [4];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_w;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign mux_y = d[sel];

    rr_mux_sel_stage #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .mux_y(mux_y), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (sel !== 2'd3) begin n_err++; $display("FAIL reset_sel: got %0d want 3", sel); end
            n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
            tick();
        end
    endtask

    task automatic test_single();
        in_valid = 4'b0100; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            d[2] = 4'hA + 4'(c);
            #1;
            n_cmp++; if (sel !== 2'd2) begin n_err++; $display("FAIL single_sel: got %0d want 2", sel); end
            n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL single_in_ready: got %b want 0100", in_ready); end
            exp_q.push_back(d[2]);
            tick();
            exp_w = exp_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL single_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_w); end
        end
        // With no requester the select parks on the last winner, and the word drains.
        in_valid = 4'b0000;
        #1;
        n_cmp++; if (sel !== 2'd2) begin n_err++; $display("FAIL idle_sel_last: got %0d want 2", sel); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL idle_in_ready: got %b want 0000", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 4'hD) begin n_err++; $display("FAIL drain_hold: got v=%b d=%h want v=0 d=d", out_valid, out_data); end
    endtask

    task automatic test_all_request();
        d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
        in_valid = 4'b0000; out_ready = 1'b1;
        do_reset();
        in_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++; if (sel !== 2'(c % 4)) begin n_err++; $display("FAIL all_sel: got %0d want %0d", sel, c % 4); end
            n_cmp++; if (in_ready !== (4'b0001 << (c % 4))) begin n_err++; $display("FAIL all_in_ready: got %b want %b", in_ready, 4'b0001 << (c % 4)); end
            exp_q.push_back(4'(c % 4 + 1));
            tick();
            exp_w = exp_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL all_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_w); end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0000; out_ready = 1'b1;
        do_reset();
        in_valid = 4'b1111;
        exp_q.push_back(4'h1);
        tick();
        exp_w = exp_q.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_w); end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready: got %b want 0000", in_ready); end
            n_cmp++; if (sel !== 2'd1) begin n_err++; $display("FAIL bp_sel: got %0d want 1", sel); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h1) begin n_err++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=1", out_valid, out_data); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 0010", in_ready); end
        exp_q.push_back(4'h2);
        tick();
        out_ready = 1'b0;
        exp_w = exp_q.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL bp_swap: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_w); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h2) begin n_err++; $display("FAIL bp_hold2: got v=%b d=%h want v=1 d=2", out_valid, out_data); end
    endtask

    task automatic test_priority_skip();
        in_valid = 4'b0000; out_ready = 1'b1;
        do_reset();
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (sel !== (c == 0 ? 2'd3 : 2'd0)) begin n_err++; $display("FAIL skip_sel: got %0d want %0d", sel, c == 0 ? 3 : 0); end
            n_cmp++; if (in_ready !== (c == 0 ? 4'b1000 : 4'b0001)) begin n_err++; $display("FAIL skip_in_ready: got %b", in_ready); end
            exp_q.push_back(c == 0 ? 4'h4 : 4'h1);
            tick();
            exp_w = exp_q.pop_front();
            n_cmp++; if (out_data !== exp_w) begin n_err++; $display("FAIL skip_out: got %h want %h", out_data, exp_w); end
        end
        #1;
        n_cmp++; if (sel !== 2'd3) begin n_err++; $display("FAIL skip_sel_wrap: got %0d want 3", sel); end
    endtask

    task automatic test_mid_reset();
        // Leaves last=0 and out_valid=1, so a reset that misses last_q shows up as a ch1 grant.
        in_valid = 4'b1111; out_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin n_err++; $display("FAIL rst_out: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
        rst = 1'b0;
        #1;
        n_cmp++; if (sel !== 2'd0 || in_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant: got sel=%0d rdy=%b want sel=0 rdy=0001", sel, in_ready); end
        exp_q.push_back(4'h1);
        tick();
        exp_w = exp_q.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL rst_first_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_w); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        d[0] = 4'h0; d[1] = 4'h0; d[2] = 4'h0; d[3] = 4'h0;
        test_reset();
        test_single();
        test_all_request();
        test_backpressure();
        test_priority_skip();
        test_mid_reset();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
